sram2_arbiter: RTL and testbench

SRAM2_ARBITER -- requirements
Module: sram2_arbiter

---
 rtl/sram2_arbiter.sv | 147 ++++++++++++++
 tb/tb_sram2_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram2_arbiter.sv
// Two-port round-robin arbiter in front of the SRAM2 window (0x1000_0000-0x1000_7FFF).
// One transaction in flight: IDLE samples and grants, ACCESS drives SRAM2 for a cycle, DONE acks.
module sram2_arbiter (
   input  logic        clock,
   input  logic        reset,
   input  logic        p0_req,
   input  logic        p0_we,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   input  logic        p1_req,
   input  logic        p1_we,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   output logic        p0_ack,
   output logic        p0_err,
   output logic        p1_ack,
   output logic        p1_err,
   output logic [31:0] rd_data,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [35:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_parity_err
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t      state, state_next;
   logic        last_grant;
   logic        grant_port;
   logic        err_pending;
   logic        lat_we;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;

   logic        any_req;
   logic        winner;
   logic        winner_we;
   logic [31:0] winner_addr;
   logic [31:0] winner_wdata;
   logic        winner_legal;
   logic [3:0]  parity;

   // On a tie the port that did not win last time takes the grant.
   always_comb begin
      any_req = p0_req | p1_req;
      winner  = 1'b0;
      if (p0_req && p1_req) begin
         winner = ~last_grant;
      end else if (p1_req) begin
         winner = 1'b1;
      end
      winner_we    = winner ? p1_we    : p0_we;
      winner_addr  = winner ? p1_addr  : p0_addr;
      winner_wdata = winner ? p1_wdata : p0_wdata;
      winner_legal = (winner_addr[31:16] == 16'h1000) && !winner_addr[15]
                     && (winner_addr[1:0] == 2'b00);
   end

   always_comb begin
      parity = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         parity[i] = ^lat_wdata[8*i +: 8];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Request latch and read/error capture; an illegal request goes to DONE with the error pre-set.
   always_ff @(posedge clock) begin
      if (reset) begin
         last_grant  <= 1'b1;
         grant_port  <= 1'b0;
         err_pending <= 1'b0;
         lat_we      <= 1'b0;
         lat_addr    <= 32'h0000_0000;
         lat_wdata   <= 32'h0000_0000;
         rd_data     <= 32'h0000_0000;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  grant_port  <= winner;
                  last_grant  <= winner;
                  lat_we      <= winner_we;
                  lat_addr    <= winner_addr;
                  lat_wdata   <= winner_wdata;
                  err_pending <= ~winner_legal;
               end
            end
            ACCESS: begin
               err_pending <= mem_parity_err;
               if (!lat_we) begin
                  rd_data <= mem_rdata;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // SRAM2 is only selected during ACCESS; acks come only from DONE.
   always_comb begin
      state_next = state;
      mem_addr   = 32'h0000_0000;
      mem_we     = 1'b0;
      mem_wdata  = 36'h0_0000_0000;
      p0_ack     = 1'b0;
      p0_err     = 1'b0;
      p1_ack     = 1'b0;
      p1_err     = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) begin
               state_next = winner_legal ? ACCESS : DONE;
            end
         end
         ACCESS: begin
            state_next = DONE;
            mem_addr   = lat_addr;
            mem_we     = lat_we;
            mem_wdata  = {parity, lat_wdata};
         end
         DONE: begin
            state_next = IDLE;
            if (grant_port) begin
               p1_ack = 1'b1;
               p1_err = err_pending;
            end else begin
               p0_ack = 1'b1;
               p0_err = err_pending;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_sram2_arbiter.sv
// Bench for sram2_arbiter: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a transaction-timing model.
module tb_sram2_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        p0_req = 1'b0, p0_we = 1'b0;
   logic [31:0] p0_addr = 32'h0, p0_wdata = 32'h0;
   logic        p1_req = 1'b0, p1_we = 1'b0;
   logic [31:0] p1_addr = 32'h0, p1_wdata = 32'h0;
   logic [31:0] mem_rdata = 32'h0;
   logic        mem_parity_err = 1'b0;
   logic        p0_ack, p0_err, p1_ack, p1_err;
   logic [31:0] rd_data, mem_addr;
   logic        mem_we;
   logic [35:0] mem_wdata;

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   sram2_arbiter dut (
      .clock(clock), .reset(reset),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p0_ack(p0_ack), .p0_err(p0_err), .p1_ack(p1_ack), .p1_err(p1_err),
      .rd_data(rd_data), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_parity_err(mem_parity_err)
   );

   task automatic checkOutput(input string name, input logic [35:0] actual, input logic [35:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
      end
   endtask

   function automatic bit is_legal(input logic [31:0] a);
      return (a >= 32'h1000_0000) && (a <= 32'h1000_7FFF) && (a % 4 == 0);
   endfunction

   function automatic logic [3:0] byte_parity(input logic [31:0] w);
      logic [3:0] p;
      for (int i = 0; i < 4; i++) begin
         p[i] = ($countones((w >> (8 * i)) & 32'h0000_00FF) % 2) == 1;
      end
      return p;
   endfunction

   // Model: a granted transaction is described by the cycle numbers of its access and its ack.
   int          cyc = 0;
   bit          model_ready = 1'b0;
   bit          m_valid = 1'b0, m_legal = 1'b0, m_we = 1'b0, m_port = 1'b0;
   bit          m_err = 1'b0, m_last = 1'b1;
   logic [31:0] m_addr = 32'h0, m_wdata = 32'h0, m_rd = 32'h0;
   int          t_acc = 0, t_ack = 0;

   always @(posedge clock) begin
      int c;
      bit pick;
      c = cyc;
      if (reset) begin
         model_ready = 1'b1;
         m_valid = 1'b0;
         m_err   = 1'b0;
         m_last  = 1'b1;
         m_rd    = 32'h0;
         t_acc   = c;
         t_ack   = c;
      end else if (model_ready) begin
         if (m_valid && m_legal && c == t_acc) begin
            m_err = mem_parity_err;
            if (!m_we) m_rd = mem_rdata;
         end
         if (c > t_ack && (p0_req || p1_req)) begin
            pick    = (p0_req && p1_req) ? !m_last : p1_req;
            m_last  = pick;
            m_port  = pick;
            m_valid = 1'b1;
            m_we    = pick ? p1_we : p0_we;
            m_addr  = pick ? p1_addr : p0_addr;
            m_wdata = pick ? p1_wdata : p0_wdata;
            m_legal = is_legal(m_addr);
            m_err   = !m_legal;
            t_acc   = c + 1;
            t_ack   = m_legal ? c + 2 : c + 1;
         end
      end
      cyc = c + 1;
   end

   always @(negedge clock) begin
      bit acc, ack;
      if (model_ready) begin
         acc = m_valid && m_legal && cyc == t_acc;
         ack = m_valid && cyc == t_ack;
         checkOutput("mem_addr", {4'h0, mem_addr}, acc ? {4'h0, m_addr} : 36'h0);
         checkOutput("mem_we", 36'(mem_we), 36'(acc && m_we));
         checkOutput("mem_wdata", mem_wdata, acc ? {byte_parity(m_wdata), m_wdata} : 36'h0);
         checkOutput("p0_ack", 36'(p0_ack), 36'(ack && !m_port));
         checkOutput("p0_err", 36'(p0_err), 36'(ack && !m_port && m_err));
         checkOutput("p1_ack", 36'(p1_ack), 36'(ack && m_port));
         checkOutput("p1_err", 36'(p1_err), 36'(ack && m_port && m_err));
         checkOutput("rd_data", {4'h0, rd_data}, {4'h0, m_rd});
      end
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic applyStimulus(input bit port, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
      if (port) begin
         p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
      end else begin
         p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
      end
   endtask

   task automatic doReset();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   function automatic logic [31:0] randAddr();
      logic [31:0] r, a;
      r = $urandom;
      case ($urandom_range(0, 7))
         0: a = (r[31:16] == 16'h1000) ? (r ^ 32'h8000_0000) : r;
         1: a = 32'h1000_8000 | (r & 32'h0000_7FFC);
         2: a = 32'h1000_0000 | (r & 32'h0000_7FFC) | 32'($urandom_range(1, 3));
         3: begin
            case (r[1:0])
               2'd0: a = 32'h1000_0000;
               2'd1: a = 32'h1000_7FFC;
               2'd2: a = 32'h1000_8000;
               default: a = 32'h0FFF_FFFC;
            endcase
         end
         default: a = 32'h1000_0000 | (r & 32'h0000_7FFC);
      endcase
      return a;
   endfunction

   task automatic newRequest(input bit port);
      applyStimulus(port, 1'($urandom_range(0, 1)), randAddr(), $urandom);
   endtask

   task automatic dropRequest(input bit port);
      if (port) p1_req = 1'b0; else p0_req = 1'b0;
   endtask

   task automatic servicePort(input bit port, inout int waits);
      bit req, ack;
      req = port ? p1_req : p0_req;
      ack = port ? p1_ack : p0_ack;
      if (req && ack) begin
         tests++;
         if (waits > 8) begin
            fails++;
            $display("[TB] FAIL p%0d_wait: actual %0d cycles, required <= 8", port, waits);
         end
         waits = 0;
         if ($urandom_range(0, 1) == 1) newRequest(port); else dropRequest(port);
      end else if (req) begin
         waits++;
         if (waits >= 20) begin
            tests++;
            fails++;
            $display("[TB] FAIL p%0d_timeout: actual no ack in %0d cycles, required ack", port, waits);
            dropRequest(port);
            waits = 0;
         end else if ($urandom_range(0, 63) == 0) begin
            dropRequest(port);
            waits = 0;
         end
      end else if ($urandom_range(0, 2) == 0) begin
         newRequest(port);
         waits = 0;
      end
   endtask

   initial begin
      int order[$];
      int ack_cyc[$];
      int wait0, wait1;

      // Reset values, then a lone legal read from port 0.
      doReset();
      checkOutput("rst_p0_ack", 36'(p0_ack), 36'h0);
      checkOutput("rst_p1_ack", 36'(p1_ack), 36'h0);
      checkOutput("rst_mem_addr", {4'h0, mem_addr}, 36'h0);
      checkOutput("rst_mem_wdata", mem_wdata, 36'h0);
      checkOutput("rst_rd_data", {4'h0, rd_data}, 36'h0);
      mem_rdata = 32'hDEAD_BEEF;
      applyStimulus(1'b0, 1'b0, 32'h1000_0010, 32'h0);
      tick();
      checkOutput("rd_access_addr", {4'h0, mem_addr}, 36'h0_1000_0010);
      checkOutput("rd_access_we", 36'(mem_we), 36'h0);
      checkOutput("rd_access_noack", 36'(p0_ack), 36'h0);
      tick();
      checkOutput("rd_ack", 36'(p0_ack), 36'h1);
      checkOutput("rd_err", 36'(p0_err), 36'h0);
      checkOutput("rd_data", {4'h0, rd_data}, 36'h0_DEAD_BEEF);
      p0_req = 1'b0;

      // Port 1 write: parity nibble is 4'b0010 (only byte1 = 0x01 has odd weight).
      tick();
      mem_rdata = 32'h1234_5678;
      applyStimulus(1'b1, 1'b1, 32'h1000_0004, 32'h00FF_0103);
      tick();
      checkOutput("wr_we", 36'(mem_we), 36'h1);
      checkOutput("wr_wdata", mem_wdata, 36'h2_00FF_0103);
      checkOutput("wr_addr", {4'h0, mem_addr}, 36'h0_1000_0004);
      tick();
      checkOutput("wr_ack", 36'(p1_ack), 36'h1);
      checkOutput("wr_err", 36'(p1_err), 36'h0);
      checkOutput("wr_rd_hold", {4'h0, rd_data}, 36'h0_DEAD_BEEF);
      p1_req = 1'b0;

      // Both ports requesting continuously after reset: strict alternation, ack every 3 cycles.
      doReset();
      mem_rdata = 32'hCAFE_F00D;
      applyStimulus(1'b0, 1'b0, 32'h1000_0100, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h1000_0200, 32'h0);
      for (int n = 1; n <= 20 && order.size() < 4; n++) begin
         tick();
         if (p0_ack) begin order.push_back(0); ack_cyc.push_back(n); end
         if (p1_ack) begin order.push_back(1); ack_cyc.push_back(n); end
      end
      p0_req = 1'b0;
      p1_req = 1'b0;
      checkOutput("rr_ack_count", 36'(order.size()), 36'd4);
      for (int i = 0; i < order.size(); i++) begin
         checkOutput($sformatf("rr_grant%0d", i), 36'(order[i]), 36'(i % 2));
         checkOutput($sformatf("rr_ackcyc%0d", i), 36'(ack_cyc[i]), 36'(2 + 3 * i));
      end

      // Illegal addresses: immediate error ack, no SRAM2 access, rd_data untouched.
      mem_rdata = 32'h0BAD_BAD0;
      foreach (order[i]) order.delete();
      for (int i = 0; i < 3; i++) begin
         logic [31:0] bad;
         bad = (i == 0) ? 32'h0800_0000 : (i == 1) ? 32'h1000_8000 : 32'h1000_0002;
         tick();
         applyStimulus(1'b0, 1'b0, bad, 32'h0);
         tick();
         checkOutput($sformatf("ill%0d_ack", i), 36'(p0_ack), 36'h1);
         checkOutput($sformatf("ill%0d_err", i), 36'(p0_err), 36'h1);
         checkOutput($sformatf("ill%0d_addr", i), {4'h0, mem_addr}, 36'h0);
         checkOutput($sformatf("ill%0d_rd", i), {4'h0, rd_data}, 36'h0_CAFE_F00D);
         p0_req = 1'b0;
      end

      // Parity error on a legal read, then reset in the middle of an access.
      tick();
      mem_rdata = 32'h1111_2222;
      mem_parity_err = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'h1000_7FFC, 32'h0);
      tick();
      tick();
      checkOutput("par_ack", 36'(p0_ack), 36'h1);
      checkOutput("par_err", 36'(p0_err), 36'h1);
      checkOutput("par_rd", {4'h0, rd_data}, 36'h0_1111_2222);
      p0_req = 1'b0;
      mem_parity_err = 1'b0;
      tick();
      applyStimulus(1'b1, 1'b0, 32'h1000_0040, 32'h0);
      tick();
      checkOutput("abort_access", {4'h0, mem_addr}, 36'h0_1000_0040);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      p1_req = 1'b0;
      checkOutput("abort_ack", 36'(p1_ack), 36'h0);
      checkOutput("abort_addr", {4'h0, mem_addr}, 36'h0);
      checkOutput("abort_we", 36'(mem_we), 36'h0);
      checkOutput("abort_rd", {4'h0, rd_data}, 36'h0);
      tick();
      checkOutput("abort_ack_later", 36'(p1_ack), 36'h0);

      // Randomized traffic with occasional resets.
      wait0 = 0;
      wait1 = 0;
      for (int n = 0; n < 3000; n++) begin
         tick();
         mem_rdata = $urandom;
         mem_parity_err = ($urandom_range(0, 7) == 0);
         if (reset) begin
            reset = 1'b0;
         end else if ($urandom_range(0, 299) == 0) begin
            reset = 1'b1;
            wait0 = 0;
            wait1 = 0;
         end
         servicePort(1'b0, wait0);
         servicePort(1'b1, wait1);
      end
      reset = 1'b0;
      p0_req = 1'b0;
      p1_req = 1'b0;
      repeat (4) tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
